// File: rtl/sme_pkg.sv
// Shared sme definitions: mask-pool FSM states and pool sizing helper.
package sme_pkg;

  localparam int SME_LANES = 25;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    SERVE  = 2'd1,
    REFILL = 2'd2
  } pool_state_t;

  // Number of whole mask words that fit in one keccak state.
  function automatic int sme_nw(input int lw, input int mw);
    return (lw * SME_LANES) / mw;
  endfunction

endpackage

// File: rtl/sme_mask_pool.sv
// Slices the sme_keccak state into mask words, serves them over valid/ready,
// and strobes the permutation to warm up after reset and to refill each pool.
module sme_mask_pool
  import sme_pkg::*;
#(
  parameter  int LW     = 8,
  parameter  int MW     = 8,
  parameter  int WARM   = 24,
  parameter  int ROUNDS = 2,
  localparam int NW     = sme_nw(LW, MW),
  localparam int WLW    = $clog2(NW + 1)
) (
  input  logic                    g_clk,
  input  logic                    g_reset,
  input  logic [LW*SME_LANES-1:0] kstate,
  output logic                    k_update,
  input  logic                    flush,
  output logic                    mask_valid,
  input  logic                    mask_ready,
  output logic [MW-1:0]           mask,
  output logic [WLW-1:0]          words_left
);

  localparam int IW   = (NW > 1) ? $clog2(NW) : 1;
  localparam int UMAX = (WARM > ROUNDS) ? WARM : ROUNDS;
  localparam int CW   = (UMAX > 1) ? $clog2(UMAX) : 1;

  localparam logic [CW-1:0] WARM_LAST  = CW'(WARM - 1);
  localparam logic [CW-1:0] ROUND_LAST = CW'(ROUNDS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NW - 1);

  pool_state_t   state;
  logic [CW-1:0] ucnt;
  logic [IW-1:0] idx;

  // NOTE: all state uses non-blocking assignments so every branch sees the
  // pre-edge values of state, ucnt and idx regardless of statement order.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state <= WARMUP;
      ucnt  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        WARMUP: begin
          if (ucnt == WARM_LAST) begin
            state <= SERVE;
            ucnt  <= '0;
            idx   <= '0;
          end else begin
            ucnt <= ucnt + CW'(1);
          end
        end
        SERVE: begin
          // A transfer on the last word and a flush both end the pool; a
          // word taken alongside the flush is already counted as delivered.
          if ((mask_ready && idx == IDX_LAST) || flush) begin
            state <= REFILL;
            ucnt  <= '0;
            idx   <= '0;
          end else if (mask_ready) begin
            idx <= idx + IW'(1);
          end
        end
        REFILL: begin
          if (flush) begin
            ucnt <= '0;
          end else if (ucnt == ROUND_LAST) begin
            state <= SERVE;
            ucnt  <= '0;
            idx   <= '0;
          end else begin
            ucnt <= ucnt + CW'(1);
          end
        end
        default: begin
          state <= WARMUP;
          ucnt  <= '0;
          idx   <= '0;
        end
      endcase
    end
  end

  // The permutation must not advance while reset holds the pool idle.
  assign k_update   = !g_reset && (state == WARMUP || state == REFILL);
  assign mask_valid = (state == SERVE);
  assign mask       = kstate[idx*MW +: MW];
  assign words_left = mask_valid ? (WLW'(NW) - WLW'(idx)) : '0;

endmodule

// File: tb/tb_sme_mask_pool.sv
// Bench for sme_mask_pool: two instances (MW=8 and MW=48) checked every cycle
// against a pool model that counts pending updates and delivered words.
module tb_sme_mask_pool;

  localparam int LW     = 8;
  localparam int KW     = LW * 25;
  localparam int WARM   = 24;
  localparam int ROUNDS = 2;
  localparam int MW0    = 8;
  localparam int MW1    = 48;
  localparam int NW0    = KW / MW0;
  localparam int NW1    = KW / MW1;

  logic          g_clk = 1'b0;
  logic          g_reset;
  logic [KW-1:0] kstate;
  logic          flush;
  logic          mask_ready;

  logic          k_update0, mask_valid0;
  logic [MW0-1:0] mask0;
  logic [$clog2(NW0+1)-1:0] words_left0;
  logic          k_update1, mask_valid1;
  logic [MW1-1:0] mask1;
  logic [$clog2(NW1+1)-1:0] words_left1;

  sme_mask_pool #(.LW(LW), .MW(MW0), .WARM(WARM), .ROUNDS(ROUNDS)) dut (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .kstate     (kstate),
    .k_update   (k_update0),
    .flush      (flush),
    .mask_valid (mask_valid0),
    .mask_ready (mask_ready),
    .mask       (mask0),
    .words_left (words_left0)
  );

  sme_mask_pool #(.LW(LW), .MW(MW1), .WARM(WARM), .ROUNDS(ROUNDS)) dut48 (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .kstate     (kstate),
    .k_update   (k_update1),
    .flush      (flush),
    .mask_valid (mask_valid1),
    .mask_ready (mask_ready),
    .mask       (mask1),
    .words_left (words_left1)
  );

  always #5 g_clk = ~g_clk;

  int checks = 0;
  int errors = 0;

  // Reference model per instance: updates still owed before serving, words
  // already taken from the current pool, and whether this is the warm-up.
  int upd_left  [2];
  int delivered [2];
  bit warm      [2];
  int nw_of     [2] = '{NW0, NW1};
  int mw_of     [2] = '{MW0, MW1};

  logic        cur_rdy, cur_fl;
  logic        last_kup, last_mv;
  int          last_wl;
  logic [63:0] last_mask;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [KW-1:0] rand_k();
    logic [KW-1:0] r;
    r = '0;
    repeat (7) r = (r << 32) | KW'($urandom());
    return r;
  endfunction

  function automatic logic [63:0] word_of(input int k, input int mw);
    logic [KW-1:0] t;
    t = kstate >> (k * mw);
    return 64'(t) & ((64'd1 << mw) - 64'd1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      upd_left[i]  = WARM;
      delivered[i] = 0;
      warm[i]      = 1'b1;
    end
  endtask

  task automatic check_inst(input int i, input logic kup, input logic mv,
                            input logic [63:0] m, input int wl);
    string p;
    bit    serving;
    p       = (i == 0) ? "mw8" : "mw48";
    serving = !g_reset && upd_left[i] == 0;
    check({p, ".k_update"}, 64'(kup), 64'(!g_reset && upd_left[i] > 0));
    check({p, ".mask_valid"}, 64'(mv), 64'(serving));
    check({p, ".words_left"}, 64'(wl), serving ? 64'(nw_of[i] - delivered[i]) : 64'd0);
    if (serving)
      check({p, ".mask"}, m, word_of(delivered[i], mw_of[i]));
    else if (g_reset)
      check({p, ".mask_rst"}, m, word_of(0, mw_of[i]));
  endtask

  // Drive inputs on the falling edge, then compare outputs mid-phase.
  task automatic drive(input logic rdy, input logic fl, input logic newk, input logic rst);
    @(negedge g_clk);
    g_reset = rst;
    if (rst) model_reset();
    mask_ready = rdy;
    flush      = fl;
    if (newk) kstate = rand_k();
    cur_rdy = rdy;
    cur_fl  = fl;
    #1;
    check_inst(0, k_update0, mask_valid0, 64'(mask0), int'(words_left0));
    check_inst(1, k_update1, mask_valid1, 64'(mask1), int'(words_left1));
    last_kup  = k_update0;
    last_mv   = mask_valid0;
    last_wl   = int'(words_left0);
    last_mask = 64'(mask0);
  endtask

  // Advance the model across the rising edge using the driven inputs.
  task automatic commit();
    @(posedge g_clk);
    if (g_reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (upd_left[i] > 0) begin
          if (cur_fl && !warm[i]) begin
            upd_left[i] = ROUNDS;
          end else begin
            upd_left[i]--;
            if (upd_left[i] == 0) begin
              warm[i]      = 1'b0;
              delivered[i] = 0;
            end
          end
        end else begin
          if (cur_rdy) delivered[i]++;
          if (delivered[i] == nw_of[i] || cur_fl) begin
            upd_left[i]  = ROUNDS;
            delivered[i] = 0;
          end
        end
      end
    end
  endtask

  initial begin
    int          n;
    int          served;
    logic [63:0] held;

    g_reset    = 1'b1;
    mask_ready = 1'b0;
    flush      = 1'b0;
    kstate     = rand_k();
    model_reset();

    // Held reset: idle outputs, no update strobe.
    repeat (3) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      commit();
    end

    // Warm-up with ready held high: 24 update cycles, then a full pool.
    n = 0;
    for (int c = 0; c < 100; c++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      if (last_mv) break;
      if (last_kup) n++;
      commit();
    end
    check("warm_done", 64'(last_mv), 64'd1);
    check("warm_len", 64'(n), 64'd24);
    check("first_words_left", 64'(last_wl), 64'd25);

    // Drain the whole pool back-to-back, then measure the refill.
    served = 1;
    commit();
    repeat (24) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      if (last_mv) served++;
      commit();
    end
    check("pool_words", 64'(served), 64'd25);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      if (last_mv) break;
      if (last_kup) n++;
      commit();
    end
    check("refill_len", 64'(n), 64'd2);
    check("refill_words_left", 64'(last_wl), 64'd25);

    // Stall at idx 7 with a fixed state: word 7 and 18 left must hold.
    commit();
    repeat (7) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      commit();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    held = 64'(kstate[56 +: 8]);
    commit();
    repeat (10) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("stall_mask", last_mask, held);
      check("stall_words_left", 64'(last_wl), 64'd18);
      commit();
    end

    // Finish the pool, refill, then flush with a transfer at idx 3.
    repeat (18) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      commit();
    end
    repeat (2) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      commit();
    end
    repeat (3) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      commit();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("flush_word3", last_mask, word_of(3, MW0));
    check("flush_words_left", 64'(last_wl), 64'd22);
    commit();
    n = 0;
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      if (last_mv) break;
      if (last_kup) n++;
      commit();
    end
    check("flush_refill_len", 64'(n), 64'd2);
    check("flush_resume_word0", last_mask, word_of(0, MW0));

    // Reset in the first refill cycle, then a full warm-up again.
    commit();
    repeat (25) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      commit();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_mask_valid", 64'(last_mv), 64'd0);
    check("rst_k_update", 64'(last_kup), 64'd0);
    commit();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    commit();
    n = 0;
    for (int c = 0; c < 100; c++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      if (last_mv) break;
      if (last_kup) n++;
      commit();
    end
    check("rewarm_len", 64'(n), 64'd24);
    commit();

    // Random traffic: back-pressure, flushes and occasional resets.
    for (int c = 0; c < 800; c++) begin
      drive(($urandom() % 4) != 0, ($urandom() % 12) == 0, 1'b1, ($urandom() % 150) == 0);
      commit();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
